// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI-Lite round-robin arbiter.
// Holds the FSM state encoding, the AXI response codes and a helper
// that sizes master-index fields so that a single master still gets a 1-bit field.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_RESP = 3'd4
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Width of an index into n requesters; never zero so NM=1 still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: combinational round-robin pick among NM requesters, starting at ptr.
// Latency: zero (pure combinational).
// Backpressure: none; callers decide when to sample gnt_idx.
// Ports:
//   req     in  NM   request vector
//   ptr     in  IW   highest-priority index this round
//   gnt_idx out IW   chosen requester (0 when gnt_any=0)
//   gnt_any out 1    at least one requester present
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NM = 2,
  localparam int IW = idx_w(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  // Distance of each requester from ptr going forward modulo NM;
  // the requester with the smallest distance wins.
  int best_off;
  int off;

  always_comb begin
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    best_off = NM;
    off      = 0;
    for (int i = 0; i < NM; i++) begin
      off = (i + NM - int'(ptr)) % NM;
      if (req[i] && (off < best_off)) begin
        best_off = off;
        gnt_idx  = IW'(i);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// Purpose: shares one AXI-Lite slave port among NM masters, round-robin, one transaction in flight.
// Latency: grant registered on the arbitration edge; response-to-IDLE 1 cycle, >=1 idle cycle between transactions.
// Backpressure: slave ready/valid is passed straight through to the granted master; others see 0 and hold.
// Ports:
//   ACLK, ARESET               clock, synchronous active-high reset
//   m_aw*/m_w*/m_b*/m_ar*/m_r* per-master AXI-Lite channels, flattened NM-wide
//   s_aw*/s_w*/s_b*/s_ar*/s_r* single slave-side AXI-Lite port toward the bridge
//   grant_o                    index of the owning master (valid while busy_o)
//   busy_o                     high whenever a transaction is in progress
module axi_lite_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  localparam int IW = idx_w(NM)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  // master side
  input  logic [NM*AW-1:0] m_awaddr,
  input  logic [NM-1:0]    m_awvalid,
  output logic [NM-1:0]    m_awready,
  input  logic [NM*DW-1:0] m_wdata,
  input  logic [NM-1:0]    m_wvalid,
  output logic [NM-1:0]    m_wready,
  output logic [NM*2-1:0]  m_bresp,
  output logic [NM-1:0]    m_bvalid,
  input  logic [NM-1:0]    m_bready,
  input  logic [NM*AW-1:0] m_araddr,
  input  logic [NM-1:0]    m_arvalid,
  output logic [NM-1:0]    m_arready,
  output logic [NM*DW-1:0] m_rdata,
  output logic [NM*2-1:0]  m_rresp,
  output logic [NM-1:0]    m_rvalid,
  input  logic [NM-1:0]    m_rready,
  // slave side
  output logic [AW-1:0]    s_awaddr,
  output logic             s_awvalid,
  input  logic             s_awready,
  output logic [DW-1:0]    s_wdata,
  output logic             s_wvalid,
  input  logic             s_wready,
  input  logic [1:0]       s_bresp,
  input  logic             s_bvalid,
  output logic             s_bready,
  output logic [AW-1:0]    s_araddr,
  output logic             s_arvalid,
  input  logic             s_arready,
  input  logic [DW-1:0]    s_rdata,
  input  logic [1:0]       s_rresp,
  input  logic             s_rvalid,
  output logic             s_rready,
  // status
  output logic [IW-1:0]    grant_o,
  output logic             busy_o
);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;

  logic [NM-1:0] req;
  logic [IW-1:0] gnt_idx;
  logic          gnt_any;

  // Granted master's handshake inputs, selected by the registered grant.
  logic g_awvalid, g_wvalid, g_arvalid, g_bready, g_rready;
  logic pick_wr;

  logic st_wr_addr, st_wr_resp, st_rd_addr, st_rd_resp;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign req = m_awvalid | m_arvalid;

  rr_arbiter #(.NM(NM)) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign st_wr_addr = (state_q == WR_ADDR);
  assign st_wr_resp = (state_q == WR_RESP);
  assign st_rd_addr = (state_q == RD_ADDR);
  assign st_rd_resp = (state_q == RD_RESP);

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign ar_hs = s_arvalid & s_arready;
  assign b_hs  = s_bvalid & s_bready;
  assign r_hs  = s_rvalid & s_rready;

  // Channel muxes and per-master demux; everything steered by grant_q.
  always_comb begin
    s_awaddr  = '0;
    s_wdata   = '0;
    s_araddr  = '0;
    g_awvalid = 1'b0;
    g_wvalid  = 1'b0;
    g_arvalid = 1'b0;
    g_bready  = 1'b0;
    g_rready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_arready = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    for (int i = 0; i < NM; i++) begin
      if (IW'(i) == grant_q) begin
        s_awaddr  = m_awaddr[i*AW +: AW];
        s_wdata   = m_wdata[i*DW +: DW];
        s_araddr  = m_araddr[i*AW +: AW];
        g_awvalid = m_awvalid[i];
        g_wvalid  = m_wvalid[i];
        g_arvalid = m_arvalid[i];
        g_bready  = m_bready[i];
        g_rready  = m_rready[i];
        m_awready[i] = st_wr_addr & s_awready & ~aw_done_q;
        m_wready[i]  = st_wr_addr & s_wready & ~w_done_q;
        m_arready[i] = st_rd_addr & s_arready;
        m_bvalid[i]  = st_wr_resp & s_bvalid;
        m_rvalid[i]  = st_rd_resp & s_rvalid;
        if (st_wr_resp) m_bresp[i*2 +: 2] = s_bresp;
        if (st_rd_resp) begin
          m_rdata[i*DW +: DW] = s_rdata;
          m_rresp[i*2 +: 2]   = s_rresp;
        end
      end
    end
  end

  // Once a channel has handshaked its valid is masked, so the slave sees
  // exactly one AW and one W regardless of the order they complete in.
  assign s_awvalid = st_wr_addr & g_awvalid & ~aw_done_q;
  assign s_wvalid  = st_wr_addr & g_wvalid & ~w_done_q;
  assign s_arvalid = st_rd_addr & g_arvalid;
  assign s_bready  = st_wr_resp & g_bready;
  assign s_rready  = st_rd_resp & g_rready;

  // Write takes precedence over read when the winning master asserts both.
  always_comb begin
    pick_wr = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (IW'(i) == gnt_idx) pick_wr = m_awvalid[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          grant_d = gnt_idx;
          state_d = pick_wr ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d = IDLE;
          ptr_d   = (grant_q == IW'(NM-1)) ? '0 : grant_q + IW'(1);
        end
      end
      RD_ADDR: begin
        if (ar_hs) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (r_hs) begin
          state_d = IDLE;
          ptr_d   = (grant_q == IW'(NM-1)) ? '0 : grant_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter with two masters; the bench plays
// both masters and the slave and checks every step against hand-derived values.
// Reset, write, read, split AW/W, write-before-read, mid-read reset, pointer order.
module tb_axi_lite_rr_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [63:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [3:0]  m_bresp, m_rresp;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;
  logic [0:0]  grant_o;
  logic        busy_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  axi_lite_rr_arbiter #(.NM(2), .AW(32), .DW(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_all();
    m_awaddr = '0; m_wdata = '0; m_araddr = '0;
    m_awvalid = '0; m_wvalid = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
    s_bvalid = 1'b0; s_bresp = 2'b00; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
  endtask

  initial begin
    // ---- T1: reset with everything asserted
    clear_all();
    ARESET = 1'b1;
    m_awvalid = 2'b11; m_wvalid = 2'b11; m_arvalid = 2'b11; m_bready = 2'b11; m_rready = 2'b11;
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1; s_bvalid = 1'b1; s_rvalid = 1'b1;
    tick(); tick();
    chk("rst_m_awready", 64'(m_awready), 64'd0);
    chk("rst_m_wready",  64'(m_wready),  64'd0);
    chk("rst_m_arready", 64'(m_arready), 64'd0);
    chk("rst_m_bvalid",  64'(m_bvalid),  64'd0);
    chk("rst_m_rvalid",  64'(m_rvalid),  64'd0);
    chk("rst_s_awvalid", 64'(s_awvalid), 64'd0);
    chk("rst_s_wvalid",  64'(s_wvalid),  64'd0);
    chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("rst_s_bready",  64'(s_bready),  64'd0);
    chk("rst_s_rready",  64'(s_rready),  64'd0);
    chk("rst_busy",      64'(busy_o),    64'd0);
    chk("rst_grant",     64'(grant_o),   64'd0);

    // ---- T2: both masters write at once; m0 first, then m1
    ARESET = 1'b0;
    clear_all();
    m_awaddr = {32'h14, 32'h10}; m_wdata = {32'h2222, 32'h1111};
    m_awvalid = 2'b11; m_wvalid = 2'b11; m_bready = 2'b11;
    tick();
    chk("t2_grant0",    64'(grant_o),   64'd0);
    chk("t2_busy",      64'(busy_o),    64'd1);
    chk("t2_s_awvalid", 64'(s_awvalid), 64'd1);
    chk("t2_s_awaddr",  64'(s_awaddr),  64'h10);
    chk("t2_s_wvalid",  64'(s_wvalid),  64'd1);
    chk("t2_s_wdata",   64'(s_wdata),   64'h1111);
    chk("t2_awready_lo", 64'(m_awready), 64'd0);
    s_awready = 1'b1; s_wready = 1'b1; settle();
    chk("t2_m_awready", 64'(m_awready), 64'b01);
    chk("t2_m_wready",  64'(m_wready),  64'b01);
    tick();
    m_awvalid = 2'b10; m_wvalid = 2'b10; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b00; settle();
    chk("t2_wresp_awv", 64'(s_awvalid), 64'd0);
    chk("t2_m_bvalid0", 64'(m_bvalid),  64'b01);
    chk("t2_m_bresp0",  64'(m_bresp),   64'h0);
    chk("t2_s_bready",  64'(s_bready),  64'd1);
    tick();
    s_bvalid = 1'b0; settle();
    chk("t2_idle_busy", 64'(busy_o),   64'd0);
    chk("t2_idle_bv",   64'(m_bvalid), 64'd0);
    tick();
    chk("t2_grant1",    64'(grant_o),  64'd1);
    chk("t2_s_awaddr1", 64'(s_awaddr), 64'h14);
    chk("t2_s_wdata1",  64'(s_wdata),  64'h2222);
    s_awready = 1'b1; s_wready = 1'b1; settle();
    chk("t2_m_awready1", 64'(m_awready), 64'b10);
    tick();
    m_awvalid = 2'b00; m_wvalid = 2'b00; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b10; settle();
    chk("t2_m_bvalid1", 64'(m_bvalid), 64'b10);
    chk("t2_m_bresp1",  64'(m_bresp),  64'b1000);
    tick();
    s_bvalid = 1'b0; s_bresp = 2'b00;

    // ---- T3: m1 read, SLVERR with data
    m_araddr = {32'h08, 32'h0}; m_arvalid = 2'b10; m_rready = 2'b11;
    tick();
    chk("t3_grant",     64'(grant_o),   64'd1);
    chk("t3_s_arvalid", 64'(s_arvalid), 64'd1);
    chk("t3_s_araddr",  64'(s_araddr),  64'h08);
    chk("t3_s_awvalid", 64'(s_awvalid), 64'd0);
    s_arready = 1'b1; settle();
    chk("t3_m_arready", 64'(m_arready), 64'b10);
    tick();
    m_arvalid = 2'b00; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'hA5A5_0001; s_rresp = 2'b10; settle();
    chk("t3_m_rvalid", 64'(m_rvalid), 64'b10);
    chk("t3_m_rdata",  m_rdata,       64'hA5A5_0001_0000_0000);
    chk("t3_m_rresp",  64'(m_rresp),  64'b1000);
    chk("t3_s_rready", 64'(s_rready), 64'd1);
    tick();
    s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; m_rready = 2'b00;

    // ---- T4: W handshakes three cycles ahead of AW
    m_awaddr = {32'h0, 32'h20}; m_wdata = {32'h0, 32'h3333};
    m_awvalid = 2'b01; m_wvalid = 2'b01; m_bready = 2'b01; s_wready = 1'b1;
    tick();
    chk("t4_grant",    64'(grant_o),   64'd0);
    chk("t4_s_wvalid", 64'(s_wvalid),  64'd1);
    chk("t4_m_wready", 64'(m_wready),  64'b01);
    chk("t4_awready0", 64'(m_awready), 64'd0);
    tick();
    chk("t4_wv_masked", 64'(s_wvalid),  64'd0);
    chk("t4_wr_masked", 64'(m_wready),  64'd0);
    chk("t4_awv_held",  64'(s_awvalid), 64'd1);
    chk("t4_busy",      64'(busy_o),    64'd1);
    tick(); tick();
    chk("t4_still_addr", 64'(s_awvalid), 64'd1);
    chk("t4_still_wlo",  64'(s_wvalid),  64'd0);
    s_awready = 1'b1; settle();
    chk("t4_m_awready", 64'(m_awready), 64'b01);
    tick();
    s_awready = 1'b0; s_wready = 1'b0; m_awvalid = 2'b00; m_wvalid = 2'b00;
    s_bvalid = 1'b1; settle();
    chk("t4_resp_awv", 64'(s_awvalid), 64'd0);
    chk("t4_m_bvalid", 64'(m_bvalid),  64'b01);
    tick();
    s_bvalid = 1'b0;

    // ---- T5: m0 asserts AW and AR together; write goes first
    m_awaddr = {32'h0, 32'h40}; m_wdata = {32'h0, 32'h5555}; m_araddr = {32'h0, 32'h44};
    m_awvalid = 2'b01; m_wvalid = 2'b01; m_arvalid = 2'b01; m_bready = 2'b01; m_rready = 2'b01;
    tick();
    chk("t5_grant",     64'(grant_o),   64'd0);
    chk("t5_s_awvalid", 64'(s_awvalid), 64'd1);
    chk("t5_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("t5_s_awaddr",  64'(s_awaddr),  64'h40);
    s_awready = 1'b1; s_wready = 1'b1;
    tick();
    m_awvalid = 2'b00; m_wvalid = 2'b00; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; settle();
    chk("t5_arready_lo", 64'(m_arready), 64'd0);
    chk("t5_m_bvalid",   64'(m_bvalid),  64'b01);
    tick();
    s_bvalid = 1'b0; settle();
    chk("t5_idle_busy", 64'(busy_o),    64'd0);
    chk("t5_idle_arv",  64'(s_arvalid), 64'd0);
    tick();
    chk("t5_rd_arv",   64'(s_arvalid), 64'd1);
    chk("t5_rd_addr",  64'(s_araddr),  64'h44);
    chk("t5_rd_grant", 64'(grant_o),   64'd0);
    s_arready = 1'b1;
    tick();
    m_arvalid = 2'b00; s_arready = 1'b0;

    // ---- T6: reset pulse while in RD_RESP, then a clean m1 write
    s_rvalid = 1'b1; s_rdata = 32'h1234; s_rresp = 2'b00; settle();
    chk("t6_pre_rvalid", 64'(m_rvalid), 64'b01);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0; settle();
    chk("t6_busy",   64'(busy_o),   64'd0);
    chk("t6_rvalid", 64'(m_rvalid), 64'd0);
    chk("t6_grant",  64'(grant_o),  64'd0);
    s_rvalid = 1'b0; s_rdata = '0; m_rready = 2'b00;
    m_awaddr = {32'h30, 32'h0}; m_wdata = {32'h4444, 32'h0};
    m_awvalid = 2'b10; m_wvalid = 2'b10; m_bready = 2'b10;
    tick();
    chk("t6_grant1",  64'(grant_o),  64'd1);
    chk("t6_awaddr",  64'(s_awaddr), 64'h30);
    chk("t6_wdata",   64'(s_wdata),  64'h4444);
    s_awready = 1'b1; s_wready = 1'b1;
    tick();
    m_awvalid = 2'b00; m_wvalid = 2'b00; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b00; settle();
    chk("t6_m_bvalid", 64'(m_bvalid), 64'b10);
    chk("t6_m_bresp",  64'(m_bresp),  64'h0);
    tick();
    s_bvalid = 1'b0; settle();
    chk("t6_done_busy", 64'(busy_o), 64'd0);

    // ---- pointer wrapped to 0 after m1: simultaneous reads go to m0
    m_araddr = {32'h58, 32'h54}; m_arvalid = 2'b11;
    tick();
    chk("ptr_wrap_grant", 64'(grant_o),  64'd0);
    chk("ptr_wrap_addr",  64'(s_araddr), 64'h54);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
